// File: rtl/spi_cmd_decoder.sv
// Frames SPI transactions from ss_n/sclk strobes, validates the 32-bit command
// word and queues accepted commands in a small FIFO drained over valid/ready.
module spi_cmd_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [31:0]                   spi_word,
    input  logic                          ss_n_sync,
    input  logic                          sclk_rise,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [1:0]                    cmd_op,
    output logic [5:0]                    cmd_addr,
    output logic [15:0]                   cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic [CNT_W-1:0]              len_err_cnt,
    output logic [CNT_W-1:0]              chk_err_cnt,
    output logic [CNT_W-1:0]              ovf_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_ss_prev;
    logic [5:0]         r_bit_cnt;
    logic               w_fall;
    logic               w_rise;
    logic               w_in_check;
    logic               w_len_bad;
    logic               w_chk_bad;
    logic               w_push;
    logic               w_full;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [23:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [23:0]        w_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign w_fall = r_ss_prev & ~ss_n_sync;
    assign w_rise = ~r_ss_prev & ss_n_sync;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of the order in which blocks are evaluated.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ss_prev <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ss_prev <= ss_n_sync;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next_state = S_RECV;
            S_RECV:  if (w_rise) w_next_state = S_CHECK;
            S_CHECK: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Decisions taken in CHECK, in priority order: length, checksum/opcode, NOP.
    always_comb begin
        busy       = (r_state != S_IDLE);
        w_in_check = (r_state == S_CHECK);
        w_len_bad  = (r_bit_cnt != 6'd32);
        w_chk_bad  = (spi_word[7:0] != (spi_word[31:24] ^ spi_word[23:16] ^ spi_word[15:8]))
                   || (spi_word[31:30] == 2'b11);
        w_push     = w_in_check & ~w_len_bad & ~w_chk_bad & (spi_word[31:30] != 2'b00);
    end

    // A strobe coincident with ss_n rising sees ss_n_sync high and is not counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt <= '0;
        end else if (r_state == S_IDLE && w_fall) begin
            r_bit_cnt <= '0;
        end else if (r_state == S_RECV && sclk_rise && !ss_n_sync && r_bit_cnt != 6'd63) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
        end
    end

    assign w_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign w_wr_en = w_push & ~w_full;
    assign w_rd_en = cmd_valid & cmd_ready;

    // NOTE: FIFO storage is not reset; the read mux below zeroes cmd_* while empty.
    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= spi_word[31:8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_level <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_err_cnt <= '0;
            chk_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else begin
            len_err_cnt <= sat_inc(len_err_cnt, w_in_check & w_len_bad);
            chk_err_cnt <= sat_inc(chk_err_cnt, w_in_check & ~w_len_bad & w_chk_bad);
            ovf_cnt     <= sat_inc(ovf_cnt, w_push & w_full);
        end
    end

    assign cmd_valid = (fifo_level != '0);
    assign w_head    = cmd_valid ? r_mem[r_rd_ptr] : 24'h0;
    assign cmd_op    = w_head[23:22];
    assign cmd_addr  = w_head[21:16];
    assign cmd_data  = w_head[15:0];

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed frames push expected commands,
// a negedge monitor pops and compares every accepted transfer.
module tb_spi_cmd_decoder;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 8;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic [31:0] spi_word  = '0;
    logic        ss_n_sync = 1'b1;
    logic        sclk_rise = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic        busy;
    logic [CNT_W-1:0] len_err_cnt;
    logic [CNT_W-1:0] chk_err_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_q[$];

    spi_cmd_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .spi_word(spi_word),
        .ss_n_sync(ss_n_sync), .sclk_rise(sclk_rise),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .fifo_level(fifo_level), .busy(busy),
        .len_err_cnt(len_err_cnt), .chk_err_cnt(chk_err_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer the DUT completes must match the queue head.
    always @(negedge clock) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got 0x%0h expected no command", {cmd_op, cmd_addr, cmd_data});
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("sb_cmd", 32'({cmd_op, cmd_addr, cmd_data}), 32'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] w);
        spi_word  = w;
        ss_n_sync = 1'b0;
        tick();
    endtask

    task automatic clock_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sclk_rise = 1'b1;
            tick();
            sclk_rise = 1'b0;
            tick();
        end
    endtask

    // Returns in the CHECK cycle (one cycle after the ss_n rise).
    task automatic end_frame(input logic coinc);
        ss_n_sync = 1'b1;
        sclk_rise = coinc;
        tick();
        sclk_rise = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input int n, input logic coinc);
        start_frame(w);
        clock_bits(n);
        end_frame(coinc);
        tick();
        tick();
    endtask

    task automatic check_counters(input string tag, input int len, input int chk, input int ovf);
        check({tag, "_len"}, 32'(len_err_cnt), 32'(len));
        check({tag, "_chk"}, 32'(chk_err_cnt), 32'(chk));
        check({tag, "_ovf"}, 32'(ovf_cnt), 32'(ovf));
    endtask

    logic [31:0] ovf_words [5] = '{32'h41A000E1, 32'h42A001E3, 32'h43A002E1, 32'h44A003E7, 32'h45A004E1};
    logic [23:0] ovf_cmds  [4] = '{24'h41A000, 24'h42A001, 24'h43A002, 24'h44A003};

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd", 32'({cmd_op, cmd_addr, cmd_data}), 32'd0);
        check_counters("rst", 0, 0, 0);

        // WRITE frame with latency and hold checks
        start_frame(32'h4A12346C);
        check("busy_recv", 32'(busy), 32'd1);
        clock_bits(32);
        exp_q.push_back(24'h4A1234);
        end_frame(1'b0);
        check("valid_n1", 32'(cmd_valid), 32'd0);
        check("busy_check", 32'(busy), 32'd1);
        tick();
        check("valid_n2", 32'(cmd_valid), 32'd1);
        check("wr_op", 32'(cmd_op), 32'h1);
        check("wr_addr", 32'(cmd_addr), 32'h0A);
        check("wr_data", 32'(cmd_data), 32'h1234);
        check("wr_level", 32'(fifo_level), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        tick();
        tick();
        check("hold_data", 32'(cmd_data), 32'h1234);
        check("hold_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        tick();
        check("drain_level", 32'(fifo_level), 32'd0);
        check("empty_cmd", 32'({cmd_op, cmd_addr, cmd_data}), 32'd0);

        // Length errors, then coincident strobe not counted
        send_frame(32'h4A12346C, 31, 1'b0);
        check_counters("len31", 1, 0, 0);
        send_frame(32'h4A12346C, 33, 1'b0);
        check_counters("len33", 2, 0, 0);
        exp_q.push_back(24'h4A1234);
        send_frame(32'h4A12346C, 32, 1'b1);
        check_counters("coinc", 2, 0, 0);
        check("coinc_level", 32'(fifo_level), 32'd0);

        // Checksum, reserved opcode, NOP
        send_frame(32'h4A123400, 32, 1'b0);
        check_counters("badchk", 2, 1, 0);
        send_frame(32'hCA1234EC, 32, 1'b0);
        check_counters("op11", 2, 2, 0);
        send_frame(32'h0A12342C, 32, 1'b0);
        check_counters("nop", 2, 2, 0);
        check("nop_level", 32'(fifo_level), 32'd0);

        // Overflow: five frames into a four-deep FIFO
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(ovf_cmds[i]);
        for (int i = 0; i < 5; i++) send_frame(ovf_words[i], 32, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check_counters("ovf", 2, 2, 1);
        check("ovf_head", 32'(cmd_data), 32'hA000);
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ovf_drain", 32'(fifo_level), 32'(3 - k));
        end
        cmd_ready = 1'b0;

        // Simultaneous push and pop at level 2, then at full
        exp_q.push_back(24'h51B001);
        exp_q.push_back(24'h52B002);
        exp_q.push_back(24'h53B003);
        send_frame(32'h51B001E0, 32, 1'b0);
        send_frame(32'h52B002E0, 32, 1'b0);
        start_frame(32'h53B003E0);
        clock_bits(32);
        end_frame(1'b0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("pp_level", 32'(fifo_level), 32'd2);
        check("pp_head", 32'(cmd_data), 32'hB002);
        exp_q.push_back(24'h54B004);
        exp_q.push_back(24'h55B005);
        send_frame(32'h54B004E0, 32, 1'b0);
        send_frame(32'h55B005E0, 32, 1'b0);
        check("pp_full", 32'(fifo_level), 32'd4);
        start_frame(32'h56B006E0);
        clock_bits(32);
        end_frame(1'b0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("ppf_level", 32'(fifo_level), 32'd3);
        check_counters("ppf", 2, 2, 2);
        check("ppf_head", 32'(cmd_data), 32'hB003);
        cmd_ready = 1'b1;
        repeat (3) tick();
        check("pp_drain", 32'(fifo_level), 32'd0);

        // Reset mid-frame, released with ss_n still low
        start_frame(32'h4A12346C);
        clock_bits(16);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mid_busy", 32'(busy), 32'd0);
        clock_bits(16);
        end_frame(1'b0);
        tick();
        tick();
        check("mid_busy2", 32'(busy), 32'd0);
        check("mid_level", 32'(fifo_level), 32'd0);
        check_counters("mid", 0, 0, 0);
        exp_q.push_back(24'h4A1234);
        send_frame(32'h4A12346C, 32, 1'b0);
        check_counters("post", 0, 0, 0);
        check("post_level", 32'(fifo_level), 32'd0);

        repeat (4) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI slave shift register.
- Frames each SPI transaction using the synchronized ss_n level and the sclk rising-edge strobe, and counts the bits received.
- At frame end, checks the received 32-bit word for length, opcode and checksum; valid commands go into a small FIFO.
- Core logic drains the FIFO through a valid/ready interface. Error counters are exposed for debug on the logic analyzer.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, range 2..16
- CNT_W, 8, width of each saturating error counter

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- spi_word  input  32  shift-register contents from the SPI slave, MSB first
- ss_n_sync  input  1  synchronized chip select, active low
- sclk_rise  input  1  one-cycle strobe per synchronized sclk rising edge
- cmd_valid  output  1  FIFO head holds a command
- cmd_ready  input  1  consumer accepts head this cycle
- cmd_op  output  2  head opcode: 01 WRITE, 10 READ
- cmd_addr  output  6  head address
- cmd_data  output  16  head data
- fifo_level  output  clog2(FIFO_DEPTH)+1  entries currently held
- busy  output  1  FSM not in IDLE
- len_err_cnt  output  CNT_W  frames whose bit count is not 32
- chk_err_cnt  output  CNT_W  checksum or reserved-opcode failures
- ovf_cnt  output  CNT_W  valid commands dropped because the FIFO was full

Behaviour:
- Word format:
  - [31:30] op; [29:24] addr; [23:8] data; [7:0] chk.
  - The checksum is good when chk == spi_word[31:24] ^ spi_word[23:16] ^ spi_word[15:8].
- Edge detect:
  - ss_prev is a register of ss_n_sync; it resets to 0.
  - fall = ss_prev & ~ss_n_sync.
  - rise = ~ss_prev & ss_n_sync.
- FSM states: IDLE, RECV, CHECK.
  - IDLE -> RECV on fall. bit_cnt is cleared to 0 in that cycle.
  - RECV: on each sclk_rise with ss_n_sync==0, bit_cnt increments. bit_cnt is 6 bits and saturates at 63. RECV -> CHECK on rise.
  - If sclk_rise and rise occur in the same cycle, the edge is not counted.
  - CHECK lasts exactly 1 cycle and samples spi_word. It always returns to IDLE.
- Decisions in CHECK, with priority from top to bottom:
  - bit_cnt != 32: len_err_cnt++.
  - Checksum bad, or op==11: chk_err_cnt++.
  - op==00 (NOP): discarded; no counter changes.
  - Otherwise, push {op, addr, data}. If fifo_level == FIFO_DEPTH at the start of the cycle, the push is dropped and ovf_cnt++.
  - All counters saturate at all-ones and never wrap.
- Latency: rise is seen in cycle N; CHECK occurs in N+1; a pushed command is visible on cmd_* and cmd_valid in N+2 when the FIFO was empty.
- FIFO behaviour:
  - cmd_valid = (fifo_level != 0).
  - A pop happens when cmd_valid & cmd_ready.
  - cmd_* show the head entry and stay stable while cmd_valid & ~cmd_ready.
  - Push and pop in the same cycle: level unchanged, order preserved.
  - Full test uses the pre-pop level, so a push is dropped when the FIFO is full even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_* are 0 when the FIFO is empty.
- Reset values:
  - FSM = IDLE; bit_cnt = 0; ss_prev = 0.
  - FIFO empty; fifo_level = 0; cmd_valid = 0; cmd_* = 0.
  - busy = 0; all counters = 0.
- Reset mid-frame:
  - Any partial frame is discarded.
  - Because ss_prev resets to 0, a frame whose ss_n_sync is already low at reset release is ignored. Decoding resumes on the next fall.
- No combinational path from cmd_ready to cmd_valid.

Test Plan:
- WRITE frame: 32 sclk_rise, spi_word = 0x4A_1234_6C (op 01, addr 0x0A, data 0x1234, chk 0x4A^0x12^0x34 = 0x6C) -> cmd_valid 2 cycles after ss_n_sync rises; cmd_op=01, cmd_addr=0x0A, cmd_data=0x1234; with cmd_ready high, one transfer and fifo_level returns to 0.
- Length error: 31 sclk_rise, then a frame with 33 sclk_rise -> len_err_cnt=2, no push; an sclk_rise coincident with rise is not counted (32 counted + 1 coincident -> accepted).
- Checksum and opcode errors: chk byte = 0x00 on the word above -> chk_err_cnt=1; op=11 with a correct chk -> chk_err_cnt=2; op=00 with a good chk -> no push, all counters unchanged.
- Overflow: cmd_ready=0, 5 valid WRITE frames with FIFO_DEPTH=4 -> fifo_level=4, ovf_cnt=1; then cmd_ready=1 -> the first four commands drain in order, one per cycle.
- Simultaneous push and pop: FIFO holding 2 entries with cmd_ready=1 while a frame completes -> level stays 2 and order is preserved; repeat at full -> the push is dropped, ovf_cnt++.
- Reset mid-frame: reset asserted after 16 sclk_rise and released with ss_n_sync still low, then 16 more edges and rise -> no push, no counter change, busy=0; the next full frame decodes normally.
